pipe_interlock_ctrl: RTL and testbench
======================================

Name: pipe_interlock_ctrl

Overview:
- Central stall/bubble sequencer for the 5-stage pipeline.
- Drives the load-dependency hold on the PC and IF/ID pipeline registers (their active-high `loaddepen` input, which blocks loading when 1).
- Also drives the ID/EX hold and flush, and the EX/MEM flush.
- Freezes the whole pipe on data-memory wait.
- Arbitrates three stall sources (load-use, multi-cycle multiply, memory wait) with fixed priority and keeps a stall performance counter.

Parameters:
- REG_W, 5, register-specifier width.
- MUL_LAT, 4, total EX cycles occupied by a multiply (legal range 1..15).
- MEM_TIMEOUT, 64, consecutive memory-wait cycles before mem_err is set.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  ID source register 1.
- id_rt  in  REG_W  ID source register 2.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_is_mul  in  1  ID instruction is a multi-cycle multiply.
- ex_valid  in  1  EX holds a real instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_wreg  in  1  EX instruction writes a register.
- ex_rd  in  REG_W  EX destination register.
- mem_req  in  1  MEM stage is issuing a data access.
- mem_ready  in  1  data memory completes the access this cycle.
- loaddepen  out  1  hold PC and IF/ID (1 = hold).
- idex_hold  out  1  ID/EX keeps its contents.
- idex_flush  out  1  ID/EX loads a NOP bubble.
- exmem_flush  out  1  EX/MEM loads a NOP bubble.
- pipe_freeze  out  1  every pipeline register holds, including MEM/WB.
- state  out  2  00 RUN, 01 MUL_BUSY, 10 MEM_WAIT.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with loaddepen=1.

Behaviour:
- Reset (clrn=0, async):
  - state=RUN, mul counter=0, wait counter=0, mem_err=0, stall_cycles=0.
  - All combinational outputs are 0 while in reset.
- Hazard terms (combinational):
  - hz = ex_valid & ex_is_load & ex_wreg & (ex_rd!=0) & id_valid & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
  - mw = mem_req & ~mem_ready.
- Priority: mw > MUL_BUSY > hz > mul issue.
- pipe_freeze:
  - pipe_freeze = mw, in any state.
  - When pipe_freeze=1, loaddepen=1 and idex_hold=1. idex_flush=0 and exmem_flush=0.
  - No state or counter advances during a freeze, except the wait counter, mem_err and stall_cycles.
- RUN, no mw:
  - If hz: loaddepen=1 and idex_flush=1 for exactly this cycle. The load moves to MEM, so the hazard clears next cycle (forwarding covers MEM→EX).
  - Else if id_valid & id_is_mul & MUL_LAT>1: the multiply issues into EX at this edge. Next state is MUL_BUSY, with the mul counter loaded to MUL_LAT-1.
  - If hz and id_is_mul occur together, hz wins and the multiply stays in ID.
- MUL_BUSY, no mw:
  - Outputs: loaddepen=1, idex_hold=1, exmem_flush=1. hz is not evaluated.
  - The mul counter decrements each cycle. When it is 1 at the edge, next state is RUN.
  - This gives exactly MUL_LAT-1 stall cycles.
- MEM_WAIT:
  - Entered from RUN or MUL_BUSY on any edge where mw=1. The prior state is saved.
  - The wait counter increments each mw cycle, saturating.
  - When the count reaches MEM_TIMEOUT, mem_err is set. mem_err clears only on reset.
  - First cycle with mw=0: the controller returns to the saved state and resumes with the counters unchanged. The wait counter clears on exit.
  - A MUL_BUSY interrupted by a freeze therefore still totals MUL_LAT-1 non-frozen stall cycles.
- stall_cycles: increments on every cycle with loaddepen=1 and saturates at all-ones.
- Register 0 never causes a hazard.
- MUL_LAT=1: a multiply issues as an ordinary instruction and MUL_BUSY is never entered.

Decomposition:
- Shared package pipe_pkg:
  - State encodings ST_RUN, ST_MUL_BUSY, ST_MEM_WAIT.
  - REG_W.
  - NOP encoding used by the flush consumers.
- One natural sub-module: hazard_detect (the combinational hz term). Instantiated once.
- Counters and FSM stay in the top level.

Test Plan:
- Reset: clrn=0 mid-MUL_BUSY with counter=2 → all outputs 0 and state=00 asynchronously. After release, stall_cycles=0.
- Load-use: EX lw with rd=8; ID add with rs=8, use_rs=1 → loaddepen=1 and idex_flush=1 for 1 cycle, then 0. stall_cycles=1.
- rd=0 and unused-operand cases: the same sequence with ex_rd=0, or with id_use_rs=0 → no stall.
- Multiply with MUL_LAT=4: id_is_mul issues → state=01 for 3 cycles with loaddepen, idex_hold and exmem_flush all 1, then RUN. stall_cycles=3.
- Freeze inside multiply: mem_req=1, mem_ready=0 for 2 cycles during the 2nd MUL_BUSY cycle → pipe_freeze=1 for 2 cycles, state=10, then state=01 resumes. The multiply still ends after 3 non-frozen cycles. stall_cycles=5.
- Timeout: mw held for 64 cycles → mem_err=1 on cycle 64 and stays 1 after mem_ready=1.
- Simultaneous hz and id_is_mul: hz bubble occurs first, then the multiply issues on the following cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline interlock controller and its consumers.
package pipe_pkg;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MUL_BUSY = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  // Instruction word the flush consumers load into a bubbled pipeline register.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: a load in EX writes a register the ID instruction reads.
module hazard_detect #(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_wreg,
  input  logic [REG_W-1:0] ex_rd,
  output logic             hz
);
  logic ld_w, rs_m, rt_m;

  // r0 is hard-wired, so a load targeting it never produces a dependency.
  assign ld_w = ex_valid & ex_is_load & ex_wreg & (ex_rd != '0);
  assign rs_m = id_use_rs & (id_rs == ex_rd);
  assign rt_m = id_use_rt & (id_rt == ex_rd);
  assign hz   = ld_w & id_valid & (rs_m | rt_m);
endmodule

// File: rtl/pipe_interlock_ctrl.sv
// Stall/bubble sequencer: load-use bubbles, multi-cycle multiply holds and
// data-memory freezes, with a saturating stall-cycle counter.
module pipe_interlock_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W       = pipe_pkg::REG_W,
  parameter int MUL_LAT     = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_mul,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_wreg,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             loaddepen,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_freeze,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic              hz, mw;
  state_t            st_q, st_d, saved_q, saved_d, eff;
  logic [3:0]        mul_q, mul_d;
  logic [WAIT_W-1:0] wait_q;
  logic              err_q;
  logic [CNT_W-1:0]  stall_q;
  logic              ld, hold, iflush, eflush;

  hazard_detect #(.REG_W(REG_W)) u_hz (
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .ex_valid  (ex_valid),
    .ex_is_load(ex_is_load),
    .ex_wreg   (ex_wreg),
    .ex_rd     (ex_rd),
    .hz        (hz)
  );

  assign mw = mem_req & ~mem_ready;

  // The first non-frozen cycle after a wait already behaves as the saved
  // state, so an interrupted multiply loses no stall cycles.
  assign eff = (st_q == ST_MEM_WAIT) ? saved_q : st_q;

  always_comb begin
    st_d    = st_q;
    saved_d = saved_q;
    mul_d   = mul_q;
    ld      = 1'b0;
    hold    = 1'b0;
    iflush  = 1'b0;
    eflush  = 1'b0;
    if (mw) begin
      ld   = 1'b1;
      hold = 1'b1;
      st_d = ST_MEM_WAIT;
      if (st_q != ST_MEM_WAIT) saved_d = st_q;
    end else if (eff == ST_MUL_BUSY) begin
      ld     = 1'b1;
      hold   = 1'b1;
      eflush = 1'b1;
      mul_d  = mul_q - 4'd1;
      st_d   = (mul_q <= 4'd1) ? ST_RUN : ST_MUL_BUSY;
    end else begin
      st_d = ST_RUN;
      if (hz) begin
        ld     = 1'b1;
        iflush = 1'b1;
      end else if (MUL_LAT > 1 && id_valid && id_is_mul) begin
        st_d  = ST_MUL_BUSY;
        mul_d = 4'(MUL_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st_q    <= ST_RUN;
      saved_q <= ST_RUN;
      mul_q   <= '0;
    end else begin
      st_q    <= st_d;
      saved_q <= saved_d;
      mul_q   <= mul_d;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else if (mw) begin
      if (wait_q != WAIT_W'(MEM_TIMEOUT)) wait_q <= wait_q + 1'b1;
      if (wait_q >= WAIT_W'(MEM_TIMEOUT - 1)) err_q <= 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                      stall_q <= '0;
    else if (ld && stall_q != '1)   stall_q <= stall_q + 1'b1;
  end

  assign loaddepen    = clrn & ld;
  assign idex_hold    = clrn & hold;
  assign idex_flush   = clrn & iflush;
  assign exmem_flush  = clrn & eflush;
  assign pipe_freeze  = clrn & mw;
  assign state        = st_q;
  assign mem_err      = err_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_interlock_ctrl.sv
// Directed bench for pipe_interlock_ctrl with a queue-based scoreboard.
module tb_pipe_interlock_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             clrn;
  logic             id_valid, id_use_rs, id_use_rt, id_is_mul;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             ex_valid, ex_is_load, ex_wreg, mem_req, mem_ready;
  logic             loaddepen, idex_hold, idex_flush, exmem_flush, pipe_freeze;
  logic [1:0]       state;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  pipe_interlock_ctrl #(.REG_W(REG_W), .MUL_LAT(4), .MEM_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .clrn(clrn),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_mul(id_is_mul),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_wreg(ex_wreg), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .loaddepen(loaddepen), .idex_hold(idex_hold), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .pipe_freeze(pipe_freeze), .state(state),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // ctrl vector: {loaddepen, idex_hold, idex_flush, exmem_flush, pipe_freeze, state}
  localparam logic [6:0] IDLE   = 7'b00000_00;
  localparam logic [6:0] BUB    = 7'b10100_00;
  localparam logic [6:0] MULB   = 7'b11010_01;
  localparam logic [6:0] FRZ_R  = 7'b11001_00;
  localparam logic [6:0] FRZ_M  = 7'b11001_01;
  localparam logic [6:0] FRZ_W  = 7'b11001_10;
  localparam logic [6:0] MULB_W = 7'b11010_10;
  localparam logic [6:0] IDLE_W = 7'b00000_10;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  sb_t q[$];
  int  errors = 0;
  int  checks = 0;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0:       return {25'b0, loaddepen, idex_hold, idex_flush, exmem_flush, pipe_freeze, state};
      1:       return {{(32-CNT_W){1'b0}}, stall_cycles};
      default: return {31'b0, mem_err};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled at the falling edge.
  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_is_mul = 0;
    ex_valid = 0; ex_is_load = 0; ex_wreg = 0; ex_rd = '0;
    mem_req = 0; mem_ready = 1;
  endtask

  task automatic load_in_ex(input logic [REG_W-1:0] rd);
    ex_valid = 1; ex_is_load = 1; ex_wreg = 1; ex_rd = rd;
  endtask

  initial begin
    idle_in();
    clrn = 1'b0;
    // reset state
    #2;
    push("reset_ctrl", 0, IDLE); push("reset_stall", 1, 0); push("reset_err", 2, 0);
    drain();
    @(posedge clk); @(posedge clk); #1;
    clrn = 1'b1;

    // load-use on rs
    id_valid = 1; id_rs = 8; id_use_rs = 1; load_in_ex(8);
    push("lu_bubble", 0, BUB); cyc();
    ex_valid = 0;
    push("lu_clear", 0, IDLE); push("lu_stall", 1, 1); cyc();

    // rd=0 never stalls
    id_rs = 0; load_in_ex(0);
    push("rd0_nostall", 0, IDLE); cyc();
    // operand not read
    id_rs = 8; id_use_rs = 0; load_in_ex(8);
    push("unused_rs", 0, IDLE); cyc();
    // load-use on rt
    id_rt = 8; id_use_rt = 1;
    push("lu_rt", 0, BUB); cyc();
    // non-writing load
    ex_wreg = 0;
    push("no_wreg", 0, IDLE); push("rt_stall", 1, 2); cyc();

    // plain multiply
    idle_in();
    id_valid = 1; id_is_mul = 1;
    push("mul_issue", 0, IDLE); cyc();
    id_is_mul = 0;
    for (int i = 0; i < 3; i++) begin
      push("mul_busy", 0, MULB); cyc();
    end
    push("mul_done", 0, IDLE); push("mul_stall", 1, 5); cyc();

    // multiply interrupted by a 2-cycle memory wait
    id_is_mul = 1;
    push("fmul_issue", 0, IDLE); cyc();
    id_is_mul = 0;
    push("fmul_a", 0, MULB); cyc();
    mem_req = 1; mem_ready = 0;
    push("fmul_frz1", 0, FRZ_M); cyc();
    push("fmul_frz2", 0, FRZ_W); cyc();
    mem_ready = 1;
    push("fmul_resume", 0, MULB_W); cyc();
    mem_req = 0;
    push("fmul_last", 0, MULB); cyc();
    push("fmul_done", 0, IDLE); push("fmul_stall", 1, 10); cyc();

    // simultaneous hazard and multiply: bubble first, then issue
    id_valid = 1; id_is_mul = 1; id_rs = 8; id_use_rs = 1; load_in_ex(8);
    push("hzmul_bubble", 0, BUB); cyc();
    ex_valid = 0;
    push("hzmul_issue", 0, IDLE); cyc();
    id_is_mul = 0;
    for (int i = 0; i < 3; i++) begin
      push("hzmul_busy", 0, MULB); cyc();
    end
    push("hzmul_done", 0, IDLE); push("hzmul_stall", 1, 14); cyc();

    // memory timeout
    idle_in();
    mem_req = 1; mem_ready = 0;
    push("to_first", 0, FRZ_R); push("to_err0", 2, 0); cyc();
    for (int i = 2; i <= 64; i++) begin
      push("to_frz", 0, FRZ_W);
      if (i == 63) push("to_err_early", 2, 0);
      cyc();
    end
    mem_ready = 1;
    push("to_exit", 0, IDLE_W); push("to_err1", 2, 1); push("to_stall", 1, 78); cyc();
    mem_req = 0;
    push("to_run", 0, IDLE); push("to_sticky", 2, 1); cyc();

    // async reset in the middle of a multiply (counter = 2)
    id_valid = 1; id_is_mul = 1;
    push("rst_issue", 0, IDLE); cyc();
    id_is_mul = 0;
    push("rst_busy", 0, MULB); cyc();
    #2;
    clrn = 1'b0;
    #1;
    push("rst_async_ctrl", 0, IDLE); push("rst_async_err", 2, 0); push("rst_async_stall", 1, 0);
    drain();
    idle_in();
    @(posedge clk); #1;
    clrn = 1'b1;
    push("rst_after", 0, IDLE); push("rst_after_stall", 1, 0); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
